// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state encoding and default timing constants for the step controller
package cpu_ctrl_pkg;

  // Encoding 2'd3 is never entered; the FSM decodes it as HALT.
  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_BAD  = 2'd3
  } cpu_state_e;

  localparam logic [27:0] DEF_DIVISOR         = 28'd2;
  localparam logic [19:0] DEF_DEBOUNCE_CYCLES = 20'd500000;

  // True on the last count of a DIVISOR-long tick period.
  function automatic logic tick_at(input logic [27:0] cnt, input logic [27:0] divisor);
    return cnt == (divisor - 28'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer plus counting debouncer with rising-edge pulse
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock_in,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic [1:0]  sync_q, sync_d;
  logic [19:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        rise_q, rise_d;

  // Accept the synchronized level only after DEBOUNCE_CYCLES disagreeing samples in a row.
  always_comb begin
    sync_d  = {sync_q[0], raw};
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = 20'd0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == (DEBOUNCE_CYCLES - 20'd1)) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
  end

  // Register synchronizer, run-length counter, accepted level and edge pulse.
  always_ff @(posedge clock_in or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      cnt_q   <= 20'd0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - divided clock-enable generator with run/halt/single-step control
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [27:0] DIVISOR         = DEF_DIVISOR,
  parameter logic [19:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic        clock_in,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        halt_req,
  output logic        cpu_ce,
  output logic        running,
  output logic        halted,
  output logic [31:0] ce_count
);

  logic        run_db;
  logic        step_db;
  logic        step_req;
  logic        tick;

  logic [27:0] tick_cnt_q, tick_cnt_d;
  cpu_state_e  state_q, state_d;
  logic        running_q, running_d;
  logic        halted_q, halted_d;
  logic        cpu_ce_q, cpu_ce_d;
  logic [31:0] ce_count_q, ce_count_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clock_in (clock_in),
    .rst      (rst),
    .raw      (run_sw),
    .level    (run_db),
    .rise     ()
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clock_in (clock_in),
    .rst      (rst),
    .raw      (step_btn),
    .level    (step_db),
    .rise     (step_req)
  );

  // Tick period counter: wraps at DIVISOR-1, so DIVISOR=1 ticks every cycle.
  always_comb begin
    tick       = tick_at(tick_cnt_q, DIVISOR);
    tick_cnt_d = tick ? 28'd0 : tick_cnt_q + 28'd1;
  end

  // Next state, sticky halt flag, enable pulse and pulse counter.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else if (!run_db) begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: begin
        // A step always completes on its tick; halt_req and further presses are ignored.
        if (tick) begin
          state_d = ST_HALT;
        end
      end
      default: begin
        // HALT, and the unused encoding treated as HALT.
        if (run_db && !halted_q) begin
          state_d = ST_RUN;
        end else if (step_req) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_HALT;
        end
      end
    endcase
    // Dropping run re-arms the core after a halt request.
    if (!run_db) begin
      halted_d = 1'b0;
    end
    cpu_ce_d   = tick & (((state_q == ST_RUN) & ~halt_req & run_db) | (state_q == ST_STEP));
    running_d  = (state_d == ST_RUN);
    ce_count_d = ce_count_q + {31'd0, cpu_ce_q};
  end

  // Controller registers; outputs are taken straight from flops.
  always_ff @(posedge clock_in or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= 28'd0;
      state_q    <= ST_HALT;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
      cpu_ce_q   <= 1'b0;
      ce_count_q <= 32'd0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      running_q  <= running_d;
      halted_q   <= halted_d;
      cpu_ce_q   <= cpu_ce_d;
      ce_count_q <= ce_count_d;
    end
  end

  assign cpu_ce   = cpu_ce_q;
  assign running  = running_q;
  assign halted   = halted_q;
  assign ce_count = ce_count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - scoreboard bench for cpu_step_ctrl at DIVISOR=4 and DIVISOR=1
module tb_cpu_step_ctrl;

  typedef struct packed {
    int          cyc;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_sw, step_btn, halt_req;
  logic        cpu_ce, running, halted;
  logic [31:0] ce_count;

  logic        rst1 = 1'b1;
  logic        run_sw1, step_btn1, halt_req1;
  logic        cpu_ce1, running1, halted1;
  logic [31:0] ce_count1;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   cyc1     = 0;
  exp_t exp_q[$];
  exp_t exp1_q[$];

  cpu_step_ctrl #(.DIVISOR(28'd4), .DEBOUNCE_CYCLES(20'd3)) dut (
    .clock_in (clk),
    .rst      (rst),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .halt_req (halt_req),
    .cpu_ce   (cpu_ce),
    .running  (running),
    .halted   (halted),
    .ce_count (ce_count)
  );

  cpu_step_ctrl #(.DIVISOR(28'd1), .DEBOUNCE_CYCLES(20'd3)) dut1 (
    .clock_in (clk),
    .rst      (rst1),
    .run_sw   (run_sw1),
    .step_btn (step_btn1),
    .halt_req (halt_req1),
    .cpu_ce   (cpu_ce1),
    .running  (running1),
    .halted   (halted1),
    .ce_count (ce_count1)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release: after active edge k it reads k.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(posedge clk or posedge rst1) begin
    if (rst1) cyc1 <= 0;
    else      cyc1 <= cyc1 + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [31:0] n);
    exp_q.push_back('{cyc: c, cnt: n});
  endtask

  task automatic push1(input int c, input logic [31:0] n);
    exp1_q.push_back('{cyc: c, cnt: n});
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait1_to(input int n);
    while (cyc1 < n) @(negedge clk);
  endtask

  // Monitor for the DIVISOR=4 instance: every pulse must match the next expected entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (cpu_ce === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        chk("pulse_count", ce_count, e.cnt);
      end
    end
  end

  // Monitor for the DIVISOR=1 instance.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (cpu_ce1 === 1'b1) begin
      if (exp1_q.size() == 0) begin
        chk("unexpected_pulse1", 32'(cyc1), 32'hFFFF_FFFF);
      end else begin
        e = exp1_q.pop_front();
        chk("pulse1_cycle", 32'(cyc1), 32'(e.cyc));
        chk("pulse1_count", ce_count1, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    run_sw = 1'b1; step_btn = 1'b0; halt_req = 1'b0;
    run_sw1 = 1'b0; step_btn1 = 1'b0; halt_req1 = 1'b0;

    // Reset held with run_sw=1: everything stays quiet.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset_flags", {29'd0, cpu_ce, running, halted}, 32'd0);
      chk("reset_count", ce_count, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push(8 + 4 * i, 32'(i));
    wait_to(5);  chk("run_not_yet", {31'd0, running}, 32'd0);
    wait_to(6);  chk("run_entered", {31'd0, running}, 32'd1);

    // Halt request in a tick cycle suppresses the pulse and latches halted.
    wait_to(23); halt_req = 1'b1;
    wait_to(24); chk("halt_running", {31'd0, running}, 32'd0);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    halt_req = 1'b0;
    wait_to(40); chk("no_restart", {31'd0, running}, 32'd0);
    chk("still_halted", {31'd0, halted}, 32'd1);
    chk("count_after_halt", ce_count, 32'd4);
    chk("queue_empty_halt", 32'(exp_q.size()), 32'd0);
    run_sw = 1'b0;
    wait_to(45); chk("halted_before_clear", {31'd0, halted}, 32'd1);
    wait_to(46); chk("halted_cleared", {31'd0, halted}, 32'd0);
    run_sw = 1'b1;
    push(56, 32'd4); push(60, 32'd5); push(64, 32'd6);
    wait_to(51); chk("rearm_not_yet", {31'd0, running}, 32'd0);
    wait_to(52); chk("rearm_running", {31'd0, running}, 32'd1);

    // Drop run, then single steps: clean press and bouncing press.
    wait_to(61); run_sw = 1'b0;
    wait_to(66); chk("run_until_db", {31'd0, running}, 32'd1);
    wait_to(67); chk("run_dropped", {31'd0, running}, 32'd0);
    wait_to(70); push(80, 32'd7); step_btn = 1'b1;
    wait_to(80); step_btn = 1'b0;
    wait_to(90); chk("count_after_step", ce_count, 32'd8);
    chk("queue_empty_step", 32'(exp_q.size()), 32'd0);
    push(104, 32'd8); step_btn = 1'b1;
    wait_to(92); step_btn = 1'b0;
    wait_to(94); step_btn = 1'b1;
    wait_to(104); step_btn = 1'b0;
    wait_to(115); chk("count_after_bounce", ce_count, 32'd9);
    chk("queue_empty_bounce", 32'(exp_q.size()), 32'd0);
    chk("halt_after_bounce", {31'd0, running}, 32'd0);

    // halt_req during STEP does not cancel the step nor set halted.
    wait_to(120); push(128, 32'd9); step_btn = 1'b1;
    wait_to(126); halt_req = 1'b1;
    wait_to(128); halt_req = 1'b0;
    wait_to(130); step_btn = 1'b0;
    wait_to(138); chk("count_step_halt", ce_count, 32'd10);
    chk("queue_empty_step_halt", 32'(exp_q.size()), 32'd0);
    chk("step_no_halted", {31'd0, halted}, 32'd0);

    // Step presses during RUN add nothing.
    wait_to(140); run_sw = 1'b1;
    for (int i = 0; i < 8; i++) push(148 + 4 * i, 32'(10 + i));
    wait_to(146); chk("run_again", {31'd0, running}, 32'd1);
    wait_to(150); step_btn = 1'b1;
    wait_to(156); step_btn = 1'b0;
    wait_to(164); step_btn = 1'b1;
    wait_to(170); step_btn = 1'b0;
    wait_to(173); run_sw = 1'b0;
    wait_to(185); chk("run_stopped", {31'd0, running}, 32'd0);
    chk("count_after_run", ce_count, 32'd18);
    chk("queue_empty_run", 32'(exp_q.size()), 32'd0);

    // Reset while a step is pending, before its tick.
    wait_to(190); step_btn = 1'b1;
    wait_to(196); chk("in_step_no_ce", {31'd0, cpu_ce}, 32'd0);
    wait_to(197); rst = 1'b1; step_btn = 1'b0;
    #1;
    chk("midreset_flags", {29'd0, cpu_ce, running, halted}, 32'd0);
    chk("midreset_count", ce_count, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_to(2);
    chk("run_db_cleared", {31'd0, dut.run_db}, 32'd0);
    chk("step_db_cleared", {31'd0, dut.step_db}, 32'd0);
    wait_to(20); chk("no_pulse_after_reset", ce_count, 32'd0);
    chk("queue_empty_reset", 32'(exp_q.size()), 32'd0);

    // DIVISOR=1: back-to-back pulses and counter wrap.
    run_sw1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    for (int i = 0; i < 6; i++) push1(7 + i, 32'(i));
    push1(13, 32'hFFFF_FFFE); push1(14, 32'hFFFF_FFFF);
    push1(15, 32'd0); push1(16, 32'd1);
    wait1_to(6); chk("div1_running", {31'd0, running1}, 32'd1);
    wait1_to(12); force dut1.ce_count_q = 32'hFFFF_FFFE;
    wait1_to(13); release dut1.ce_count_q;
    wait1_to(16); rst1 = 1'b1;
    @(negedge clk);
    chk("queue_empty_div1", 32'(exp1_q.size()), 32'd0);
    chk("queue_empty_final", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
